// File: rtl/freq_beacon_tx_if.sv
// Control/output bundle of the optical beacon transmitter.
// master = control logic, slave = the transmitter itself.
interface freq_beacon_tx_if;
  logic       en;
  logic [1:0] sel;
  logic       sel_load;
  logic       led_out;
  logic       busy;
  logic [1:0] active_sel;
  logic       period_done;

  modport master (
    output en, sel, sel_load,
    input  led_out, busy, active_sel, period_done
  );

  modport slave (
    input  en, sel, sel_load,
    output led_out, busy, active_sel, period_done
  );
endinterface

// File: rtl/freq_beacon_tx.sv
// Square-wave beacon: 100/200/300/400 Hz tones on an emitter pin,
// full-length periods only, code changes applied on period boundaries.
module freq_beacon_tx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  freq_beacon_tx_if.slave bus
);

  localparam logic [CNT_W-1:0] HM0 = CNT_W'(CLK_HZ / 200 - 1);
  localparam logic [CNT_W-1:0] HM1 = CNT_W'(CLK_HZ / 400 - 1);
  localparam logic [CNT_W-1:0] HM2 = CNT_W'(CLK_HZ / 600 - 1);
  localparam logic [CNT_W-1:0] HM3 = CNT_W'(CLK_HZ / 800 - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hm;
  logic [1:0]       act;
  logic [1:0]       psel;
  logic             pflag;
  logic             led;
  logic             bsy;
  logic             pdone;
  logic             last;

  always_comb begin
    hm = HM0;
    unique case (act)
      2'd0: hm = HM0;
      2'd1: hm = HM1;
      2'd2: hm = HM2;
      2'd3: hm = HM3;
      default: hm = HM0;
    endcase
  end

  assign last = (cnt == hm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      act   <= '0;
      psel  <= '0;
      pflag <= 1'b0;
      led   <= 1'b0;
      bsy   <= 1'b0;
      pdone <= 1'b0;
    end else begin
      pdone <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.sel_load) begin
            act   <= bus.sel;
            pflag <= 1'b0;
          end
          if (bus.en) begin
            state <= HIGH;
            led   <= 1'b1;
            bsy   <= 1'b1;
          end
        end
        HIGH: begin
          if (bus.sel_load) begin
            psel  <= bus.sel;
            pflag <= 1'b1;
          end
          if (last) begin
            cnt   <= '0;
            state <= LOW;
            led   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (last) begin
            cnt   <= '0;
            pflag <= 1'b0;
            // A load landing on the boundary beats any queued code
            if (bus.sel_load) begin
              act <= bus.sel;
            end else if (pflag) begin
              act <= psel;
            end
            if (bus.en) begin
              state <= HIGH;
              led   <= 1'b1;
            end else begin
              state <= IDLE;
              bsy   <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            // Registered pulse lands on the final LOW cycle
            pdone <= (cnt == hm - 1'b1);
            if (bus.sel_load) begin
              psel  <= bus.sel;
              pflag <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          led   <= 1'b0;
          bsy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led_out     = led;
  assign bus.busy        = bsy;
  assign bus.active_sel  = act;
  assign bus.period_done = pdone;

endmodule
